// File: rtl/toggle_decoder.sv
// toggle_decoder: turns edges on per-channel toggle lines back into discrete events.
// Events are arbitrated lowest-index-first into a small FIFO and delivered over
// valid/ready. Each channel has a wrapping event counter; ovf is sticky on lost events.
// Optional feature macro: TOGGLE_DEC_SYNC_EN adds a two-flop synchronizer on tog_in.
module toggle_decoder #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8,
    localparam int unsigned CH_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    tog_in,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CH_W-1:0] ev_chan,
    output logic [N-1:0]    pend,
    output logic            ovf,
    input  logic [CH_W-1:0] cnt_sel,
    output logic [CW-1:0]   cnt_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [N-1:0]    tog_s;
    logic [N-1:0]    tog_q;
    logic [N-1:0]    chg;

    logic [N-1:0]    pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    lost;
    logic [N-1:0]    gnt_vec;

    logic            gnt_found;
    logic [CH_W-1:0] gnt_idx;
    logic            pop, push, can_push;

    logic [CH_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            ev_valid_q, ev_valid_d;
    logic [CH_W-1:0] ev_chan_q, ev_chan_d;

    logic [CW-1:0]   cnt_q [N];

`ifdef TOGGLE_DEC_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer; keeps loading during rst so the baseline is the live level.
    always_ff @(posedge clk) begin
        sync1_q <= tog_in;
        sync2_q <= sync1_q;
    end

    assign tog_s = sync2_q;
`else
    assign tog_s = tog_in;
`endif

    // Last sampled line level; also loaded during rst so reset sets the edge baseline.
    always_ff @(posedge clk) begin
        tog_q <= tog_s;
    end

    assign chg = tog_s ^ tog_q;

    // Fixed-priority arbiter: scanning downwards leaves the lowest pending index.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(i);
            end
        end
    end

    assign pop      = ev_valid_q & ev_ready;
    assign can_push = (count_q != FULL) | pop;
    assign push     = gnt_found & can_push;
    assign gnt_vec  = push ? (N'(1) << gnt_idx) : '0;

    // A new edge always (re)arms pend; it is lost only if pend is held and not granted.
    assign pend_d = chg | (pend_q & ~gnt_vec);
    assign lost   = chg & pend_q & ~gnt_vec;
    assign ovf_d  = ovf_q | (|lost);

    // FIFO pointer/occupancy update and the next registered head.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        ev_valid_d = (count_d != '0);
        ev_chan_d  = ev_chan_q;
        if (count_d != '0) begin
            // The entry becoming head may be the one written this very cycle.
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                ev_chan_d = gnt_idx;
            end else begin
                ev_chan_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control state: pending flags, sticky overflow, FIFO pointers and output head.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_chan_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ev_valid_q <= ev_valid_d;
            ev_chan_q  <= ev_chan_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

    // Per-channel event counters; count every edge, including lost ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (chg[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Counter read mux; out-of-range selects read as zero.
    always_comb begin
        cnt_out = '0;
        if (32'(cnt_sel) < N) begin
            cnt_out = cnt_q[cnt_sel];
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_chan  = ev_chan_q;
    assign pend     = pend_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Bench for toggle_decoder: directed table, hand-written corner sequences and a
// randomized run, all also compared every cycle against a queue-based reference model.
module tb_toggle_decoder;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
`ifdef TOGGLE_DEC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] tog_in;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_chan;
    logic [N-1:0] pend;
    logic         ovf;
    logic [1:0]   cnt_sel;
    logic [CW-1:0] cnt_out;

    int checks   = 0;
    int failures = 0;

    toggle_decoder #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .tog_in   (tog_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_chan  (ev_chan),
        .pend     (pend),
        .ovf      (ovf),
        .cnt_sel  (cnt_sel),
        .cnt_out  (cnt_out)
    );

    always #5 clk = ~clk;

    // Reference model state: lines, pending set, event queue, counters.
    logic [N-1:0] m_s1 = '0, m_s2 = '0;
    logic [N-1:0] m_prev = '0;
    logic [N-1:0] m_pend = '0;
    int           m_q[$];
    int           m_cnt[N];
    int           m_head = 0;
    bit           m_ovf = 0;
    bit           model_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs held at that edge.
    task automatic model_step();
        logic [N-1:0] ts;
        bit pop, can;
        int g;
`ifdef TOGGLE_DEC_SYNC_EN
        ts = m_s2;
        m_s2 = m_s1;
        m_s1 = tog_in;
`else
        ts = tog_in;
`endif
        if (rst) begin
            m_prev = ts;
            m_pend = '0;
            m_q.delete();
            m_ovf = 0;
            m_head = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            pop = (m_q.size() > 0) && ev_ready;
            can = (m_q.size() < DEPTH) || pop;
            g = -1;
            for (int i = 0; i < N; i++) if (m_pend[i] && g < 0) g = i;
            if (pop) void'(m_q.pop_front());
            if (g >= 0 && can) begin
                m_q.push_back(g);
                m_pend[g] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (ts[i] != m_prev[i]) begin
                    m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
                    if (m_pend[i]) m_ovf = 1;
                    m_pend[i] = 1'b1;
                end
            end
            m_prev = ts;
            if (m_q.size() > 0) m_head = m_q[0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (model_on) begin
            chk("model_valid", 32'(ev_valid), 32'(m_q.size() > 0));
            chk("model_chan", 32'(ev_chan), 32'(m_head));
            chk("model_pend", 32'(pend), 32'(m_pend));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
            chk("model_cnt", 32'(cnt_out), 32'(m_cnt[cnt_sel]));
        end
    endtask

    task automatic read_cnt(input int sel, output int val);
        cnt_sel = 2'(sel);
        #1;
        val = int'(cnt_out);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       ready;
        logic [1:0] sel;
        logic       exp_valid;
        logic [1:0] exp_chan;
        logic [3:0] exp_pend;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int v, first, nval, lastc, nbad;
        logic [N-1:0] mask;

        // Simultaneous edges on 3, 1, 0: queued lowest first; ev_chan held at 2 beforehand.
        tbl[0] = '{1'b1, 2'd3, 1'b0, 2'd2, 4'b1011, 8'd1};
        tbl[1] = '{1'b1, 2'd0, 1'b1, 2'd0, 4'b1010, 8'd1};
        tbl[2] = '{1'b1, 2'd1, 1'b1, 2'd1, 4'b1000, 8'd1};
        tbl[3] = '{1'b1, 2'd2, 1'b1, 2'd3, 4'b0000, 8'd1};
        tbl[4] = '{1'b1, 2'd3, 1'b0, 2'd3, 4'b0000, 8'd1};

        // Reset baseline with non-zero line levels.
        tog_in = 4'b1010;
        rst = 1'b1;
        ev_ready = 1'b0;
        cnt_sel = '0;
        repeat (3) tick();
        model_on = 1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("base_valid", 32'(ev_valid), 32'd0);
        chk("base_pend", 32'(pend), 32'd0);
        chk("base_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < N; i++) begin
            read_cnt(i, v);
            chk("base_cnt", 32'(v), 32'd0);
        end

        // Single event on channel 2.
        ev_ready = 1'b1;
        tog_in[2] = ~tog_in[2];
        first = -1;
        nval = 0;
        lastc = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (ev_valid) begin
                if (first < 0) first = t;
                nval++;
                lastc = int'(ev_chan);
            end
        end
        chk("single_latency", 32'(first), 32'(LAT));
        chk("single_count", 32'(nval), 32'd1);
        chk("single_chan", 32'(lastc), 32'd2);
        read_cnt(2, v);
        chk("single_cnt", 32'(v), 32'd1);

        // Table-driven simultaneous-edge sequence.
        tog_in = tog_in ^ 4'b1011;
        repeat (LAT - 2) tick();
        for (int r = 0; r < 5; r++) begin
            ev_ready = tbl[r].ready;
            cnt_sel = tbl[r].sel;
            tick();
            chk("tbl_valid", 32'(ev_valid), 32'(tbl[r].exp_valid));
            chk("tbl_chan", 32'(ev_chan), 32'(tbl[r].exp_chan));
            chk("tbl_pend", 32'(pend), 32'(tbl[r].exp_pend));
            chk("tbl_cnt", 32'(cnt_out), 32'(tbl[r].exp_cnt));
        end

        // Backpressure: 6 edges on channel 0, 2 cycles apart, with ev_ready low.
        do_reset();
        ev_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tog_in[0] = ~tog_in[0];
            tick();
            tick();
        end
        repeat (LAT) tick();
        chk("bp_valid", 32'(ev_valid), 32'd1);
        chk("bp_chan", 32'(ev_chan), 32'd0);
        chk("bp_pend", 32'(pend), 32'b0001);
        chk("bp_ovf", 32'(ovf), 32'd1);
        read_cnt(0, v);
        chk("bp_cnt0", 32'(v), 32'd6);
        ev_ready = 1'b1;
        nval = 0;
        nbad = 0;
        for (int t = 0; t < 12; t++) begin
            if (ev_valid) begin
                nval++;
                if (ev_chan != 2'd0) nbad++;
            end
            tick();
        end
        chk("bp_delivered", 32'(nval), 32'd5);
        chk("bp_wrong_chan", 32'(nbad), 32'd0);
        chk("bp_pend_drained", 32'(pend), 32'd0);
        chk("bp_ovf_sticky", 32'(ovf), 32'd1);

        // Counter wrap: 257 edges on channel 1.
        do_reset();
        ev_ready = 1'b1;
        for (int k = 0; k < 257; k++) begin
            tog_in[1] = ~tog_in[1];
            tick();
        end
        repeat (LAT + 2) tick();
        read_cnt(1, v);
        chk("wrap_cnt1", 32'(v), 32'd1);
        read_cnt(0, v);
        chk("wrap_cnt0", 32'(v), 32'd0);
        chk("wrap_ovf", 32'(ovf), 32'd0);

        // Mid-operation reset with a full queue, a pending flag and ovf set.
        do_reset();
        ev_ready = 1'b0;
        tog_in = ~tog_in;
        repeat (LAT + 4) tick();
        tog_in[0] = ~tog_in[0];
        tick();
        tick();
        tog_in[0] = ~tog_in[0];
        repeat (LAT) tick();
        chk("mid_pre_valid", 32'(ev_valid), 32'd1);
        chk("mid_pre_ovf", 32'(ovf), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_valid", 32'(ev_valid), 32'd0);
        chk("mid_ovf", 32'(ovf), 32'd0);
        chk("mid_pend", 32'(pend), 32'd0);
        chk("mid_chan", 32'(ev_chan), 32'd0);
        for (int i = 0; i < N; i++) begin
            read_cnt(i, v);
            chk("mid_cnt", 32'(v), 32'd0);
        end
        ev_ready = 1'b1;
        nval = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (ev_valid) nval++;
        end
        chk("mid_no_events", 32'(nval), 32'd0);

        // Randomized traffic against the reference model, with occasional resets.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < N; b++) mask[b] = ($urandom_range(0, 3) == 0);
            tog_in = tog_in ^ mask;
            ev_ready = (t % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cnt_sel = 2'($urandom_range(0, N - 1));
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
